// File: rtl/alu_seq.sv
// alu_seq: registered ALU with valid/ready handshakes on both sides.
// Ops: ADD, SUB, NOR, LD, RST complete on the accept edge. SHL and SHR
// shift one bit per clock. The result and flags are held until downstream
// accepts them.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   in_valid / in_ready    request handshake (in_ready is high only in IDLE)
//   a, b                   operands
//   alu_sel                10=ADD 11=SUB 01=NOR 00=use load_shift
//   load_shift             11=SHR 01=SHL 10=LD 00=RST (when alu_sel=00)
//   shamt                  shift amount for SHL/SHR
//   out_valid / out_ready  result handshake
//   result, cout, zout     registered result, carry/borrow/shift-out, zero
module alu_seq #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           a,
    input  logic [WIDTH-1:0]           b,
    input  logic [1:0]                 alu_sel,
    input  logic [1:0]                 load_shift,
    input  logic [$clog2(WIDTH)-1:0]   shamt,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           result,
    output logic                       cout,
    output logic                       zout
);

    localparam int unsigned SHAMT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   work_q, work_d;
    logic [SHAMT_W-1:0] count_q, count_d;
    logic               shl_q, shl_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               cout_q, cout_d;
    logic               zout_q, zout_d;

    logic [WIDTH:0]     sum_c;
    logic [WIDTH-1:0]   op_res_c;
    logic               op_cout_c;
    logic               op_done_c;
    logic [WIDTH-1:0]   shift_res_c;
    logic               shift_out_c;

    // Next-state and datapath; every register holds unless a case below updates it.
    always_comb begin
        state_d   = state_q;
        work_d    = work_q;
        count_d   = count_q;
        shl_d     = shl_q;
        result_d  = result_q;
        cout_d    = cout_q;
        zout_d    = zout_q;
        op_res_c  = '0;
        op_cout_c = 1'b0;
        op_done_c = 1'b0;

        sum_c = {1'b0, a} + {1'b0, b};

        // One-bit zero-fill shift of the working register.
        if (shl_q) begin
            shift_res_c = {work_q[WIDTH-2:0], 1'b0};
            shift_out_c = work_q[WIDTH-1];
        end else begin
            shift_res_c = {1'b0, work_q[WIDTH-1:1]};
            shift_out_c = work_q[0];
        end

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    op_done_c = 1'b1;
                    unique case (alu_sel)
                        2'b10: begin
                            op_res_c  = sum_c[WIDTH-1:0];
                            op_cout_c = sum_c[WIDTH];
                        end
                        2'b11: begin
                            op_res_c  = a - b;
                            op_cout_c = (a < b);
                        end
                        2'b01: op_res_c = ~(a | b);
                        default: begin
                            unique case (load_shift)
                                2'b11, 2'b01: begin
                                    if (shamt == '0) begin
                                        op_res_c = a;
                                    end else begin
                                        // Multi-bit shift: hand off to SHIFT.
                                        op_done_c = 1'b0;
                                        work_d    = a;
                                        count_d   = shamt;
                                        shl_d     = (load_shift == 2'b01);
                                        state_d   = SHIFT;
                                    end
                                end
                                2'b10:   op_res_c = a;
                                default: op_res_c = '0;
                            endcase
                        end
                    endcase
                    if (op_done_c) begin
                        result_d = op_res_c;
                        cout_d   = op_cout_c;
                        zout_d   = (op_res_c == '0);
                        state_d  = DONE;
                    end
                end
            end
            SHIFT: begin
                work_d  = shift_res_c;
                count_d = count_q - SHAMT_W'(1);
                // Last bit: publish result and flags together.
                if (count_q == SHAMT_W'(1)) begin
                    result_d = shift_res_c;
                    cout_d   = shift_out_c;
                    zout_d   = (shift_res_c == '0);
                    state_d  = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            work_q   <= '0;
            count_q  <= '0;
            shl_q    <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
            zout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            work_q   <= work_d;
            count_q  <= count_d;
            shl_q    <= shl_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            zout_q   <= zout_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign cout      = cout_q;
    assign zout      = zout_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed testbench for alu_seq (WIDTH=8 instance plus a WIDTH=16 instance).
module tb_alu_seq;

    logic        clk;
    logic        rst_n;

    logic        in_valid, in_ready, out_valid, out_ready, cout, zout;
    logic [7:0]  a, b, result;
    logic [1:0]  alu_sel, load_shift;
    logic [2:0]  shamt;

    logic        in_valid16, in_ready16, out_valid16, out_ready16, cout16, zout16;
    logic [15:0] a16, b16, result16;
    logic [1:0]  alu_sel16, load_shift16;
    logic [3:0]  shamt16;

    int passed = 0;
    int total  = 0;

    alu_seq #(.WIDTH(8)) u8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .alu_sel(alu_sel), .load_shift(load_shift), .shamt(shamt),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .cout(cout), .zout(zout)
    );

    alu_seq #(.WIDTH(16)) u16 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid16), .in_ready(in_ready16),
        .a(a16), .b(b16), .alu_sel(alu_sel16), .load_shift(load_shift16), .shamt(shamt16),
        .out_valid(out_valid16), .out_ready(out_ready16),
        .result(result16), .cout(cout16), .zout(zout16)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op on the 8-bit DUT, check latency and outputs, then drain it.
    task automatic run8(input string tag, input logic [7:0] av, input logic [7:0] bv,
                        input logic [1:0] sel, input logic [1:0] ls, input logic [2:0] sh,
                        input int extra, input logic [7:0] er, input logic ec, input logic ez);
        chk({tag, "/in_ready_before"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1; a = av; b = bv; alu_sel = sel; load_shift = ls; shamt = sh;
        tick();
        in_valid = 1'b0;
        a = 8'($urandom); b = 8'($urandom); shamt = 3'($urandom);
        for (int i = 0; i < extra; i++) begin
            chk({tag, "/busy_valid"}, 32'(out_valid), 32'd0);
            tick();
        end
        chk({tag, "/out_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "/result"},    32'(result),    32'(er));
        chk({tag, "/cout"},      32'(cout),      32'(ec));
        chk({tag, "/zout"},      32'(zout),      32'(ez));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "/drained"},   32'(out_valid), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
        alu_sel = '0; load_shift = '0; shamt = '0;
        in_valid16 = 1'b0; out_ready16 = 1'b0; a16 = '0; b16 = '0;
        alu_sel16 = '0; load_shift16 = '0; shamt16 = '0;

        #3;
        chk("rst/in_ready",  32'(in_ready),  32'd1);
        chk("rst/out_valid", 32'(out_valid), 32'd0);
        chk("rst/result",    32'(result),    32'd0);
        chk("rst/cout",      32'(cout),      32'd0);
        chk("rst/zout",      32'(zout),      32'd0);
        #9 rst_n = 1'b1;
        tick();

        run8("add_f0_20", 8'hF0, 8'h20, 2'b10, 2'b00, 3'd0, 0, 8'h10, 1'b1, 1'b0);
        run8("add_80_80", 8'h80, 8'h80, 2'b10, 2'b00, 3'd0, 0, 8'h00, 1'b1, 1'b1);
        run8("sub_05_07", 8'h05, 8'h07, 2'b11, 2'b00, 3'd0, 0, 8'hFE, 1'b1, 1'b0);
        run8("sub_33_33", 8'h33, 8'h33, 2'b11, 2'b00, 3'd0, 0, 8'h00, 1'b0, 1'b1);
        run8("shl_81_s3", 8'h81, 8'h00, 2'b00, 2'b01, 3'd3, 3, 8'h08, 1'b0, 1'b0);
        run8("shr_05_s1", 8'h05, 8'h00, 2'b00, 2'b11, 3'd1, 1, 8'h02, 1'b1, 1'b0);
        run8("shr_5a_s0", 8'h5A, 8'h00, 2'b00, 2'b11, 3'd0, 0, 8'h5A, 1'b0, 1'b0);

        // Backpressure: result held, no new op taken while out_ready is low.
        in_valid = 1'b1; a = 8'h12; b = 8'h34; alu_sel = 2'b10;
        tick();
        chk("bp/out_valid0", 32'(out_valid), 32'd1);
        chk("bp/result0",    32'(result),    32'h46);
        for (int i = 0; i < 5; i++) begin
            a = 8'($urandom); b = 8'($urandom); in_valid = ~in_valid;
            alu_sel = 2'b11;
            tick();
            chk("bp/hold_result", 32'(result),    32'h46);
            chk("bp/hold_cout",   32'(cout),      32'd0);
            chk("bp/hold_zout",   32'(zout),      32'd0);
            chk("bp/in_ready",    32'(in_ready),  32'd0);
            chk("bp/out_valid",   32'(out_valid), 32'd1);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp/release_valid", 32'(out_valid), 32'd0);
        chk("bp/release_ready", 32'(in_ready),  32'd1);
        chk("bp/idle_retain",   32'(result),    32'h46);

        // Reset while shifting aborts immediately.
        in_valid = 1'b1; a = 8'hFF; alu_sel = 2'b00; load_shift = 2'b01; shamt = 3'd7;
        tick();
        in_valid = 1'b0;
        tick(); tick(); tick();
        chk("mid/busy", 32'(out_valid), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("mid/out_valid", 32'(out_valid), 32'd0);
        chk("mid/result",    32'(result),    32'd0);
        chk("mid/cout",      32'(cout),      32'd0);
        chk("mid/zout",      32'(zout),      32'd0);
        chk("mid/in_ready",  32'(in_ready),  32'd1);
        #2 rst_n = 1'b1;
        tick();
        run8("add_01_01", 8'h01, 8'h01, 2'b10, 2'b00, 3'd0, 0, 8'h02, 1'b0, 1'b0);

        run8("nor_00_00", 8'h00, 8'h00, 2'b01, 2'b00, 3'd0, 0, 8'hFF, 1'b0, 1'b0);
        run8("ld_00",     8'h00, 8'h55, 2'b00, 2'b10, 3'd5, 0, 8'h00, 1'b0, 1'b1);
        run8("shl_03_s2", 8'h03, 8'h00, 2'b00, 2'b01, 3'd2, 2, 8'h0C, 1'b0, 1'b0);
        run8("rst_aa",    8'hAA, 8'hFF, 2'b00, 2'b00, 3'd4, 0, 8'h00, 1'b0, 1'b1);

        // 16-bit instance: carry out of bit 15.
        chk("w16/in_ready", 32'(in_ready16), 32'd1);
        in_valid16 = 1'b1; a16 = 16'hFFFF; b16 = 16'h0001; alu_sel16 = 2'b10;
        tick();
        in_valid16 = 1'b0; a16 = '0;
        chk("w16/out_valid", 32'(out_valid16), 32'd1);
        chk("w16/result",    32'(result16),    32'h0000);
        chk("w16/cout",      32'(cout16),      32'd1);
        chk("w16/zout",      32'(zout16),      32'd1);
        out_ready16 = 1'b1;
        tick();
        out_ready16 = 1'b0;
        chk("w16/drained",   32'(out_valid16), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
